// File: rtl/mv_collect.sv
// mv_collect: gathers skewed per-row PE results into one vector and
// hands it to a consumer over a valid/ready handshake.
//
// Parameters: DIMENSION rows per vector, WIDTH bits per element,
//             TIMEOUT max cycles spent in COLLECT (1..255).
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active low
//   mv_in      packed row results, slice i = [(i+1)*WIDTH-1 : i*WIDTH]
//   row_vld    per-row valid pulses
//   out_rdy    consumer ready
//   vec_out    assembled vector (0 unless vec_vld)
//   vec_vld    vector valid (FULL state)
//   busy       collecting or holding a vector
//   ovf        sticky: a row result was dropped
//   tmo        sticky: a collection timed out
//   frame_cnt  completed handshakes, wraps at 256
// Build option: define MV_COLLECT_RELU_EN to clamp negative slices
// to zero when they are captured.
module mv_collect #(
   parameter int DIMENSION = 16,
   parameter int WIDTH     = 8,
   parameter int TIMEOUT   = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DIMENSION*WIDTH-1:0] mv_in,
   input  logic [DIMENSION-1:0]       row_vld,
   input  logic                       out_rdy,
   output logic [DIMENSION*WIDTH-1:0] vec_out,
   output logic                       vec_vld,
   output logic                       busy,
   output logic                       ovf,
   output logic                       tmo,
   output logic [7:0]                 frame_cnt
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      FULL
   } state_t;

   state_t                       state;
   state_t                       state_nxt;
   logic [DIMENSION-1:0]         mask;
   logic [DIMENSION-1:0]         mask_nxt;
   logic [DIMENSION-1:0]         cap;
   logic [DIMENSION*WIDTH-1:0]   hold;
   logic [7:0]                   tcnt;
   logic [7:0]                   tcnt_nxt;
   logic                         ovf_set;
   logic                         tmo_set;
   logic                         hs;

   function automatic logic [WIDTH-1:0] relu(
      input logic [WIDTH-1:0] v
   );
`ifdef MV_COLLECT_RELU_EN
      return v[WIDTH-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   always_comb begin
      state_nxt = state;
      mask_nxt  = mask;
      cap       = '0;
      tcnt_nxt  = tcnt;
      ovf_set   = 1'b0;
      tmo_set   = 1'b0;
      hs        = 1'b0;
      unique case (state)
         IDLE: begin
            cap      = row_vld & ~mask;
            mask_nxt = mask | cap;
            if (|row_vld) begin
               state_nxt = COLLECT;
               tcnt_nxt  = '0;
            end
         end
         COLLECT: begin
            // A mask completed on the previous edge moves to FULL
            // here, giving one cycle between last capture and valid.
            if (&mask) begin
               state_nxt = FULL;
               ovf_set   = |row_vld;
            end else begin
               cap      = row_vld & ~mask;
               ovf_set  = |(row_vld & mask);
               mask_nxt = mask | cap;
               if (tcnt == TO_LAST && !(&mask_nxt)) begin
                  tmo_set   = 1'b1;
                  mask_nxt  = '0;
                  state_nxt = IDLE;
               end else begin
                  tcnt_nxt = tcnt + 8'd1;
               end
            end
         end
         FULL: begin
            hs = out_rdy;
            if (out_rdy) begin
               // Rows arriving with the handshake open the next frame.
               cap       = row_vld;
               mask_nxt  = row_vld;
               tcnt_nxt  = '0;
               state_nxt = (|row_vld) ? COLLECT : IDLE;
            end else begin
               ovf_set = |row_vld;
            end
         end
         default: begin
            state_nxt = IDLE;
            mask_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         mask      <= '0;
         hold      <= '0;
         tcnt      <= '0;
         ovf       <= 1'b0;
         tmo       <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state <= state_nxt;
         mask  <= mask_nxt;
         tcnt  <= tcnt_nxt;
         for (int i = 0; i < DIMENSION; i++) begin
            if (cap[i]) begin
               hold[i*WIDTH +: WIDTH] <=
                  relu(mv_in[i*WIDTH +: WIDTH]);
            end
         end
         ovf <= ovf | ovf_set;
         tmo <= tmo | tmo_set;
         if (hs) begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

   assign vec_vld = (state == FULL);
   assign busy    = (state != IDLE);
   assign vec_out = vec_vld ? hold : '0;

endmodule

// File: tb/tb_mv_collect.sv
// tb_mv_collect: directed and randomized bench for mv_collect with a
// row-array reference model and a handshake scoreboard queue.
module tb_mv_collect;

   localparam int DIM = 16;
   localparam int W   = 8;
   localparam int TO  = 64;
   localparam int DW  = DIM * W;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] mv_in = '0;
   logic [DIM-1:0] row_vld = '0;
   logic          out_rdy = 1'b0;
   logic [DW-1:0] vec_out;
   logic          vec_vld;
   logic          busy;
   logic          ovf;
   logic          tmo;
   logic [7:0]    frame_cnt;

   mv_collect #(.DIMENSION(DIM), .WIDTH(W), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .mv_in     (mv_in),
      .row_vld   (row_vld),
      .out_rdy   (out_rdy),
      .vec_out   (vec_out),
      .vec_vld   (vec_vld),
      .busy      (busy),
      .ovf       (ovf),
      .tmo       (tmo),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: which rows have arrived, their values, and
   // whether a finished vector is waiting for the consumer
   logic [W-1:0]  m_val [DIM];
   bit            m_have [DIM];
   bit            m_full, m_coll, m_ovf, m_tmo, mon_en;
   int            m_age, m_cnt;
   logic [DW-1:0] exp_q [$];

   function automatic void chk(string name, logic [DW-1:0] act,
                               logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic logic [W-1:0] clampv(logic [W-1:0] v);
`ifdef MV_COLLECT_RELU_EN
      return ($signed(v) < 0) ? '0 : v;
`else
      return v;
`endif
   endfunction

   function automatic bit all_have();
      foreach (m_have[i]) if (!m_have[i]) return 0;
      return 1;
   endfunction

   function automatic logic [DW-1:0] m_vec();
      logic [DW-1:0] v = '0;
      foreach (m_val[i]) v[i*W +: W] = m_val[i];
      return v;
   endfunction

   function automatic void m_clear();
      foreach (m_have[i]) m_have[i] = 0;
   endfunction

   function automatic void m_capture();
      for (int i = 0; i < DIM; i++) begin
         if (row_vld[i]) begin
            if (m_have[i]) m_ovf = 1;
            else begin
               m_have[i] = 1;
               m_val[i]  = clampv(mv_in[i*W +: W]);
            end
         end
      end
   endfunction

   // one clock edge of the reference behaviour, using the inputs
   // that were presented to the DUT at that edge
   function automatic void model_edge();
      if (!rst) begin
         m_clear();
         foreach (m_val[i]) m_val[i] = '0;
         m_full = 0; m_coll = 0; m_ovf = 0; m_tmo = 0;
         m_age = 0; m_cnt = 0;
         exp_q.delete();
         mon_en = 1;
         return;
      end
      if (m_full) begin
         if (out_rdy) begin
            m_cnt  = (m_cnt + 1) % 256;
            m_full = 0;
            m_clear();
            if (row_vld != 0) begin
               m_capture();
               m_coll = 1;
               m_age  = 0;
            end
         end else if (row_vld != 0) begin
            m_ovf = 1;
         end
      end else if (m_coll) begin
         if (all_have()) begin
            if (row_vld != 0) m_ovf = 1;
            m_full = 1;
            m_coll = 0;
            exp_q.push_back(m_vec());
         end else begin
            m_capture();
            m_age++;
            if (m_age == TO && !all_have()) begin
               m_tmo  = 1;
               m_coll = 0;
               m_clear();
            end
         end
      end else if (row_vld != 0) begin
         m_capture();
         m_coll = 1;
         m_age  = 0;
      end
   endfunction

   task automatic step(input bit r, input logic [DIM-1:0] rv,
                       input logic [DW-1:0] d, input bit rdy);
      rst     = r;
      row_vld = rv;
      mv_in   = d;
      out_rdy = rdy;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   function automatic logic [DW-1:0] rvec();
      logic [DW-1:0] v;
      for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [DW-1:0] one_slice(int i, logic [W-1:0] x);
      logic [DW-1:0] v = '0;
      v[i*W +: W] = x;
      return v;
   endfunction

   // monitor: compares every cycle against the model and pops the
   // scoreboard whenever the DUT offers a vector that will be taken
   always @(negedge clk) begin
      if (mon_en) begin
         chk("vec_vld", vec_vld, m_full);
         chk("busy", busy, m_full | m_coll);
         chk("ovf", ovf, m_ovf);
         chk("tmo", tmo, m_tmo);
         chk("frame_cnt", frame_cnt, m_cnt[7:0]);
         chk("vec_out", vec_out, m_full ? m_vec() : '0);
         if (vec_vld && out_rdy && rst) begin
            chk("hs_queue_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) chk("hs_vec", vec_out, exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [DW-1:0] d, snap;
      logic [W-1:0]  e2;
      int            ord [DIM];
      int            mode, nrows, tmpi;

      step(0, '0, '0, 0);
      step(0, '0, '0, 0);

      // skewed fill, slice i = i+1
      for (int i = 0; i < DIM; i++)
         step(1, DIM'(1) << i, one_slice(i, W'(i + 1)), 1);
      step(1, '0, '0, 1);
      chk("fill_vld", vec_vld, 1);
      for (int i = 0; i < DIM; i++)
         chk($sformatf("fill_slice%0d", i), vec_out[i*W +: W], i + 1);
      step(1, '0, '0, 1);
      chk("fill_cnt", frame_cnt, 1);
      chk("fill_vld_drop", vec_vld, 0);

      // backpressure
      d = rvec();
      for (int i = 0; i < DIM; i++) step(1, DIM'(1) << i, d, 0);
      step(1, '0, '0, 0);
      snap = vec_out;
      for (int k = 0; k < 10; k++) begin
         step(1, '0, rvec(), 0);
         chk("bp_vld", vec_vld, 1);
         chk("bp_stable", vec_out, snap);
      end
      step(1, '0, '0, 1);
      chk("bp_cnt", frame_cnt, 2);
      chk("bp_done", vec_vld, 0);

      // duplicate row 3
      step(0, '0, '0, 0);
      step(1, DIM'(8), one_slice(3, 8'd5), 0);
      step(1, DIM'(8), one_slice(3, 8'd9), 0);
      chk("dup_ovf", ovf, 1);
      step(1, ~DIM'(8), rvec(), 0);
      step(1, '0, '0, 0);
      chk("dup_slice3", vec_out[3*W +: W], 5);
      step(1, '0, '0, 1);

      // timeout with rows 0..7 only
      step(0, '0, '0, 0);
      for (int i = 0; i < 8; i++) step(1, DIM'(1) << i, rvec(), 1);
      for (int k = 0; k < TO - 8; k++) step(1, '0, rvec(), 1);
      chk("tmo_before", tmo, 0);
      chk("busy_before", busy, 1);
      step(1, '0, '0, 1);
      chk("tmo_after", tmo, 1);
      chk("busy_after", busy, 0);
      for (int k = 0; k < 4; k++) step(1, '0, '0, 1);

      // back-to-back: row 0 arrives with the handshake
      step(0, '0, '0, 0);
      step(1, '1, rvec(), 0);
      step(1, '0, '0, 0);
      step(1, DIM'(1), one_slice(0, 8'h2A), 1);
      chk("b2b_cnt", frame_cnt, 1);
      chk("b2b_busy", busy, 1);
      chk("b2b_vld", vec_vld, 0);
      step(1, ~DIM'(1), rvec(), 0);
      step(1, '0, '0, 0);
      chk("b2b_slice0", vec_out[0 +: W], 8'h2A);
      step(1, '0, '0, 1);
      chk("b2b_cnt2", frame_cnt, 2);

      // negative capture and reset mid-collect
      step(0, '0, '0, 0);
      d = '0;
      for (int i = 0; i < DIM; i++) d[i*W +: W] = 8'h11;
      d[2*W +: W] = 8'hF0;
      step(1, '1, d, 0);
      step(1, '0, '0, 0);
`ifdef MV_COLLECT_RELU_EN
      e2 = '0;
`else
      e2 = 8'hF0;
`endif
      chk("relu_slice2", vec_out[2*W +: W], e2);
      step(1, '0, '0, 1);
      for (int i = 0; i < 4; i++) step(1, DIM'(1) << i, rvec(), 0);
      step(0, '0, '0, 0);
      chk("rst_vec", vec_out, 0);
      chk("rst_vld", vec_vld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_tmo", tmo, 0);
      chk("rst_cnt", frame_cnt, 0);

      // randomized frames
      for (int f = 0; f < 60; f++) begin
         for (int i = 0; i < DIM; i++) ord[i] = i;
         for (int i = DIM - 1; i > 0; i--) begin
            int j = $urandom_range(0, i);
            tmpi = ord[i]; ord[i] = ord[j]; ord[j] = tmpi;
         end
         mode  = $urandom_range(0, 9);
         nrows = (mode <= 1) ? $urandom_range(1, DIM - 1) : DIM;
         for (int r = 0; r < nrows; r++) begin
            logic [DIM-1:0] rv;
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++)
               step(1, '0, rvec(), 1'($urandom_range(0, 1)));
            rv = DIM'(1) << ord[r];
            if ($urandom_range(0, 15) == 0)
               rv = rv | (DIM'(1) << $urandom_range(0, DIM - 1));
            step(1, rv, rvec(), 1'($urandom_range(0, 1)));
         end
         if (mode == 0) begin
            for (int k = 0; k < TO + 4; k++)
               step(1, '0, rvec(), 1'($urandom_range(0, 1)));
         end else if (mode == 1) begin
            step(0, '0, rvec(), 1'($urandom_range(0, 1)));
         end else begin
            int idle = $urandom_range(1, 6);
            for (int k = 0; k < idle; k++)
               step(1, '0, rvec(), 1'($urandom_range(0, 1)));
         end
      end
      for (int k = 0; k < 8; k++) step(1, '0, '0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
